uart_rx_joiner: RTL and testbench
=================================

UART_RX_JOINER -- requirements
Module: uart_rx_joiner

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 5208 at defaults).
REQ-003 Parameter TIMEOUT_BITS, 20, idle bit-times after which a partially assembled word is discarded.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 RXD  input  1  asynchronous serial line: 8N1, LSB first, idle high.
REQ-007 byteOut  output  8  last correctly framed byte.
REQ-008 byteValid  output  1  one-cycle pulse, byteOut updated.
REQ-009 wordOut  output  32  last assembled word, first received byte in [31:24].
REQ-010 wordValid  output  1  one-cycle pulse, wordOut updated.
REQ-011 frameErr  output  1  one-cycle pulse on a stop bit sampled low.

Function
REQ-012 RXD SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Bit FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: synchronized RXD = 0 -> START, bit-timer cleared.
REQ-015 START: at timer = CLKS_PER_BIT/2 - 1, sample; 0 -> DATA with timer cleared, 1 -> IDLE (glitch, no output).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, shift in LSB first; after the 8th sample -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 -> byteOut loaded, byteValid pulsed next cycle; 0 -> frameErr pulsed next cycle, byteOut unchanged; both -> IDLE.
REQ-018 FSM SHALL return to IDLE at the stop-bit midpoint so a back-to-back start bit is detected.
REQ-019 Assembler: on byteValid, shift register = {reg[23:0], byteOut} and byte count increments (0..3).
REQ-020 On the byteValid completing the 4th byte, wordOut SHALL be loaded and wordValid pulsed the following cycle; count returns to 0.
REQ-021 frameErr SHALL clear byte count and shift register in the same cycle; wordOut keeps its previous value.
REQ-022 If count != 0 and no byteValid occurs for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles, count SHALL clear; wordValid not asserted.
REQ-023 Timeout counter SHALL saturate, and restart on every byteValid.
REQ-024 byteValid, wordValid, frameErr SHALL never exceed one cycle high; frameErr and byteValid never coincide.

Reset
REQ-025 rst SHALL force FSM to IDLE, synchronizer flops to 1, all timers/counters to 0.
REQ-026 Reset values: byteOut 0x00, wordOut 0x00000000, byteValid 0, wordValid 0, frameErr 0.
REQ-027 Reset mid-frame SHALL discard the frame; the first falling edge after reset release starts a new frame.

Structure
REQ-028 Shared package/include uart_pkg SHALL hold the FSM state encodings and the CLKS_PER_BIT derivation, shared with the existing transmitter.
REQ-029 Bit-level receive (REQ-012..018) SHALL be sub-module uart_rx_byte; uart_rx_joiner instantiates it and implements assembly and timeout.

Verification (defaults, 5208 clk/bit)
REQ-030 Send 0x31,0x32,0x33,0x34 back-to-back -> four byteValid pulses, then one wordValid with wordOut = 0x31323334.
REQ-031 Hold RXD low 1000 cycles, then high -> no byteValid, no frameErr, FSM in IDLE.
REQ-032 Send 0xA5 with stop bit 0 -> frameErr pulse, no byteValid; then 0x01,0x02,0x03,0x04 -> wordOut = 0x01020304.
REQ-033 Send 0x11,0x22, idle 25 bit-times, send 0x33,0x44,0x55,0x66 -> single wordValid, wordOut = 0x33445566.
REQ-034 Assert rst during data bit 4 of a frame, then send 0x7E -> byteOut = 0x7E, no frameErr, all outputs at reset values while rst high.
REQ-035 Send 0x00 and 0xFF at BAUD +/-2% sender clock -> both bytes received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-level FSM state encoding, frame geometry and
// baud divider derivation used by both receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned WORD_BYTES = 4;

    // Integer clocks per serial bit; fractional remainder is dropped.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: synchronizes RXD, finds the start-bit midpoint and
// samples data/stop bits one bit period apart.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rxd_meta_q;
    logic                 rxd_sync_q;
    uart_state_e          state_q;
    logic [TW-1:0]        timer_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           byte_q;
    logic                 byte_valid_q;
    logic                 frame_err_q;

    // Two-flop synchronizer, idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    timer_q   <= '0;
                    bit_cnt_q <= '0;
                    if (!rxd_sync_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    // A line already high again at mid-start was a glitch.
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        state_q <= rxd_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {rxd_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    // Leave at the stop midpoint so a back-to-back start is seen.
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                        if (rxd_sync_q) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_rx_joiner.sv
// Joins received bytes into 32-bit words (first byte in the MSBs), dropping a
// partial word on a framing error or after an idle timeout.
module uart_rx_joiner
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RXD,
    output logic [7:0]  byteOut,
    output logic        byteValid,
    output logic [31:0] wordOut,
    output logic        wordValid,
    output logic        frameErr
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W        = $clog2(TMO_LIMIT + 1);
    localparam int unsigned CW           = $clog2(WORD_BYTES);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_LIMIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WORD_BYTES - 1);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    logic [23:0]      shift_q;
    logic [CW-1:0]    count_q;
    logic [TMO_W-1:0] tmo_q;
    logic [31:0]      word_q;
    logic             word_valid_q;
    logic             timeout_c;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk          (clk),
        .rst          (rst),
        .rxd_i        (RXD),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    // Fires on the TMO_LIMIT-th consecutive cycle without a byte.
    assign timeout_c = (count_q != '0) && !rx_valid && (tmo_q == TMO_LAST);

    // Idle timer: restarts on each byte, saturates so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (rx_valid) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            count_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (rx_ferr || timeout_c) begin
                shift_q <= '0;
                count_q <= '0;
            end else if (rx_valid) begin
                shift_q <= {shift_q[15:0], rx_byte};
                if (count_q == CNT_LAST) begin
                    word_q       <= {shift_q, rx_byte};
                    word_valid_q <= 1'b1;
                    count_q      <= '0;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign byteOut   = rx_byte;
    assign byteValid = rx_valid;
    assign frameErr  = rx_ferr;
    assign wordOut   = word_q;
    assign wordValid = word_valid_q;

endmodule

// File: tb/tb_uart_rx_joiner.sv
// Bench for uart_rx_joiner at 16 clocks per bit: directed scenarios plus random
// frames, checked against a byte/word list model of the joiner.
module tb_uart_rx_joiner;

    localparam int unsigned CLK_FREQ     = 1600000;
    localparam int unsigned BAUD         = 100000;
    localparam int unsigned TIMEOUT_BITS = 20;
    localparam int          CPB          = 16;
    localparam int          BIT_T        = CPB * 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        RXD;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic [31:0] wordOut;
    logic        wordValid;
    logic        frameErr;

    int tests = 0;
    int fails = 0;

    logic [7:0]  got_bytes[$];
    logic [31:0] got_words[$];
    int          got_fe = 0;
    int          pulse_viol = 0;
    logic        pbv = 1'b0, pwv = 1'b0, pfe = 1'b0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];
    logic [7:0]  acc[$];
    int          exp_fe = 0;
    int          gap_bits = 0;
    logic [7:0]  last_good = 8'h00;

    always #5 clk = ~clk;

    uart_rx_joiner #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RXD       (RXD),
        .byteOut   (byteOut),
        .byteValid (byteValid),
        .wordOut   (wordOut),
        .wordValid (wordValid),
        .frameErr  (frameErr)
    );

    // Capture output events and flag pulses wider than a cycle or overlapping.
    always @(negedge clk) begin
        if (byteValid === 1'b1) got_bytes.push_back(byteOut);
        if (wordValid === 1'b1) got_words.push_back(wordOut);
        if (frameErr === 1'b1) got_fe++;
        if ((byteValid === 1'b1 && pbv) || (wordValid === 1'b1 && pwv) ||
            (frameErr === 1'b1 && pfe) || (byteValid === 1'b1 && frameErr === 1'b1))
            pulse_viol++;
        pbv = (byteValid === 1'b1);
        pwv = (wordValid === 1'b1);
        pfe = (frameErr === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: good frames append a byte; 4 bytes make a word; framing
    // errors and gaps of TIMEOUT_BITS or more between bytes drop the partial word.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        gap_bits += 10;
        if (!stop_ok) begin
            exp_fe++;
            acc.delete();
        end else begin
            if (acc.size() != 0 && gap_bits >= TIMEOUT_BITS) acc.delete();
            exp_bytes.push_back(b);
            last_good = b;
            acc.push_back(b);
            gap_bits = 0;
            if (acc.size() == 4) begin
                exp_words.push_back({acc[0], acc[1], acc[2], acc[3]});
                acc.delete();
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input int idle_bits,
                        input int bit_t);
        @(negedge clk);
        #1;
        RXD = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            #(bit_t);
        end
        RXD = stop_ok;
        #(bit_t);
        RXD = 1'b1;
        model_frame(b, stop_ok);
        if (idle_bits > 0) #(idle_bits * bit_t);
        gap_bits += idle_bits;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, "_nwords"}, 32'(got_words.size()), 32'(exp_words.size()));
        for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got_words[i], exp_words[i]);
        chk({tag, "_nferr"}, 32'(got_fe), 32'(exp_fe));
        chk({tag, "_byteOut"}, 32'(byteOut), 32'(last_good));
        chk({tag, "_wordOut"}, wordOut,
            (exp_words.size() != 0) ? exp_words[exp_words.size() - 1] : 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_byteOut"},   32'(byteOut),   32'h0);
        chk({tag, "_byteValid"}, 32'(byteValid), 32'h0);
        chk({tag, "_wordOut"},   wordOut,        32'h0);
        chk({tag, "_wordValid"}, 32'(wordValid), 32'h0);
        chk({tag, "_frameErr"},  32'(frameErr),  32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         ok;
        int         idle;
        int         bt;

        rst = 1'b1;
        RXD = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Four back-to-back bytes form one word.
        send(8'h31, 1'b1, 0, BIT_T);
        send(8'h32, 1'b1, 0, BIT_T);
        send(8'h33, 1'b1, 0, BIT_T);
        send(8'h34, 1'b1, 2, BIT_T);
        check_all("b2b");
        chk("b2b_value", wordOut, 32'h31323334);

        // Low pulse shorter than half a bit is rejected as a glitch.
        @(negedge clk);
        #1;
        RXD = 1'b0;
        #((CPB / 2 - 3) * 10);
        RXD = 1'b1;
        #(4 * BIT_T);
        gap_bits += 5;
        check_all("glitch");

        // Framing error drops nothing but the frame; next word assembles cleanly.
        send(8'hA5, 1'b0, 1, BIT_T);
        check_all("ferr");
        send(8'h01, 1'b1, 0, BIT_T);
        send(8'h02, 1'b1, 0, BIT_T);
        send(8'h03, 1'b1, 0, BIT_T);
        send(8'h04, 1'b1, 1, BIT_T);
        check_all("after_ferr");
        chk("after_ferr_value", wordOut, 32'h01020304);

        // Idle timeout discards a two-byte partial word.
        send(8'h11, 1'b1, 0, BIT_T);
        send(8'h22, 1'b1, 25, BIT_T);
        send(8'h33, 1'b1, 0, BIT_T);
        send(8'h44, 1'b1, 0, BIT_T);
        send(8'h55, 1'b1, 0, BIT_T);
        send(8'h66, 1'b1, 1, BIT_T);
        check_all("timeout");
        chk("timeout_value", wordOut, 32'h33445566);

        // Reset in the middle of data bit 4, then a fresh frame.
        @(negedge clk);
        #1;
        rb = 8'hC3;
        RXD = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            RXD = rb[i];
            #(BIT_T);
        end
        RXD = rb[4];
        #(BIT_T / 2);
        rst = 1'b1;
        RXD = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk_reset_outputs("midrst_hold");
        rst = 1'b0;
        got_bytes.delete();
        got_words.delete();
        got_fe = 0;
        exp_bytes.delete();
        exp_words.delete();
        acc.delete();
        exp_fe = 0;
        gap_bits = 0;
        last_good = 8'h00;
        #(2 * BIT_T);
        send(8'h7E, 1'b1, 1, BIT_T);
        check_all("post_rst");

        // Sender clock about 2% fast and slow.
        send(8'h00, 1'b1, 0, BIT_T - 3);
        send(8'hFF, 1'b1, 1, BIT_T - 3);
        send(8'h00, 1'b1, 0, BIT_T + 3);
        send(8'hFF, 1'b1, 1, BIT_T + 3);
        check_all("baud_tol");

        // Random frames, rates, errors and gaps.
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            if (!ok) idle = 1;
            else if ($urandom_range(0, 9) == 0) idle = 25 + int'($urandom_range(0, 5));
            else idle = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       bt = BIT_T - 3;
                1:       bt = BIT_T + 3;
                default: bt = BIT_T;
            endcase
            send(rb, ok, idle, bt);
            chk($sformatf("rnd%0d_byteOut", n), 32'(byteOut), 32'(last_good));
        end
        #(BIT_T);
        check_all("random");

        chk("pulse_rules", 32'(pulse_viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
